// File: rtl/cpu_req_master.sv
// CPU-side initiator for the cache_controller port: queues commands, issues one request at a time,
// returns one response per command and keeps transaction/timeout statistics.
module cpu_req_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cpu_read,
  output logic        cpu_write,
  output logic [31:0] cpu_address,
  output logic [31:0] cpu_wdata,
  input  logic [7:0]  cpu_data_out,
  input  logic        ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count,
  output logic [15:0] last_latency
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 65;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [EW-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_cmd_ready, w_cmd_ready_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_cpu_read, w_cpu_read_nxt;
  logic          r_cpu_write, w_cpu_write_nxt;
  logic [31:0]   r_cpu_address, w_cpu_address_nxt;
  logic [31:0]   r_cpu_wdata, w_cpu_wdata_nxt;
  logic          r_op_write, w_op_write_nxt;
  logic [15:0]   r_lat, w_lat_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0]    r_rsp_data, w_rsp_data_nxt;
  logic          r_rsp_write, w_rsp_write_nxt;
  logic          r_rsp_err, w_rsp_err_nxt;
  logic [15:0]   r_txn_count, w_txn_count_nxt;
  logic [7:0]    r_err_count, w_err_count_nxt;
  logic [15:0]   r_last_latency, w_last_latency_nxt;

  logic          w_push, w_pop;
  logic [EW-1:0] w_head;

  // cmd_ready comes from the registered count, so a push is never bypassed to the pop side.
  assign w_push = cmd_valid && r_cmd_ready;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_head = r_fifo_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cpu_read_nxt     = r_cpu_read;
    w_cpu_write_nxt    = r_cpu_write;
    w_cpu_address_nxt  = r_cpu_address;
    w_cpu_wdata_nxt    = r_cpu_wdata;
    w_op_write_nxt     = r_op_write;
    w_lat_nxt          = r_lat;
    w_rsp_valid_nxt    = r_rsp_valid;
    w_rsp_data_nxt     = r_rsp_data;
    w_rsp_write_nxt    = r_rsp_write;
    w_rsp_err_nxt      = r_rsp_err;
    w_txn_count_nxt    = r_txn_count;
    w_err_count_nxt    = r_err_count;
    w_last_latency_nxt = r_last_latency;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_op_write_nxt    = w_head[64];
          w_cpu_address_nxt = w_head[63:32];
          w_cpu_wdata_nxt   = w_head[31:0];
          w_cpu_read_nxt    = !w_head[64];
          w_cpu_write_nxt   = w_head[64];
          w_lat_nxt         = 16'd1;
          w_state_nxt       = S_REQ;
        end
      end
      S_REQ: begin
        // ready is checked first so a completion on the timeout cycle is not reported as an error.
        if (ready) begin
          w_cpu_read_nxt  = 1'b0;
          w_cpu_write_nxt = 1'b0;
          w_rsp_data_nxt  = r_op_write ? 8'h00 : cpu_data_out;
          w_rsp_write_nxt = r_op_write;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else if (r_lat == 16'(TIMEOUT_CYCLES)) begin
          w_cpu_read_nxt  = 1'b0;
          w_cpu_write_nxt = 1'b0;
          w_rsp_data_nxt  = 8'h00;
          w_rsp_write_nxt = r_op_write;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          if (r_err_count != 8'hFF) w_err_count_nxt = r_err_count + 8'd1;
          w_state_nxt     = S_RESP;
        end else begin
          w_lat_nxt = r_lat + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt    = 1'b0;
          w_txn_count_nxt    = r_txn_count + 16'd1;
          w_last_latency_nxt = r_lat;
          w_state_nxt        = S_GAP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_cmd_ready_nxt = (w_count_nxt != CW'(FIFO_DEPTH));
    w_busy_nxt      = (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_cmd_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_cpu_read     <= 1'b0;
      r_cpu_write    <= 1'b0;
      r_cpu_address  <= '0;
      r_cpu_wdata    <= '0;
      r_op_write     <= 1'b0;
      r_lat          <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_write    <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_txn_count    <= '0;
      r_err_count    <= '0;
      r_last_latency <= '0;
    end else begin
      r_state        <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count        <= w_count_nxt;
      r_cmd_ready    <= w_cmd_ready_nxt;
      r_busy         <= w_busy_nxt;
      r_cpu_read     <= w_cpu_read_nxt;
      r_cpu_write    <= w_cpu_write_nxt;
      r_cpu_address  <= w_cpu_address_nxt;
      r_cpu_wdata    <= w_cpu_wdata_nxt;
      r_op_write     <= w_op_write_nxt;
      r_lat          <= w_lat_nxt;
      r_rsp_valid    <= w_rsp_valid_nxt;
      r_rsp_data     <= w_rsp_data_nxt;
      r_rsp_write    <= w_rsp_write_nxt;
      r_rsp_err      <= w_rsp_err_nxt;
      r_txn_count    <= w_txn_count_nxt;
      r_err_count    <= w_err_count_nxt;
      r_last_latency <= w_last_latency_nxt;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign busy         = r_busy;
  assign cpu_read     = r_cpu_read;
  assign cpu_write    = r_cpu_write;
  assign cpu_address  = r_cpu_address;
  assign cpu_wdata    = r_cpu_wdata;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_write    = r_rsp_write;
  assign rsp_err      = r_rsp_err;
  assign txn_count    = r_txn_count;
  assign err_count    = r_err_count;
  assign last_latency = r_last_latency;
endmodule
